// File: rtl/dsi_pkg.sv
// dsi_pkg: shared types for the DSI byte-to-lane distributor.
// Holds the distributor FSM encoding and the lane-count helpers.
package dsi_pkg;

  localparam int LANE_MAX_SUPPORTED = 4;

  typedef logic [2:0] lane_cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_DRAIN,
    ST_DONE
  } dist_state_t;

  // Requested lane count clamped to what the instance was built with.
  function automatic lane_cnt_t eff_lanes(
    input logic [1:0] cfg,
    input int         max_lanes
  );
    int n;
    n = int'(cfg) + 1;
    if (n > max_lanes) n = max_lanes;
    if (n > LANE_MAX_SUPPORTED) n = LANE_MAX_SUPPORTED;
    return lane_cnt_t'(n);
  endfunction

endpackage

// File: rtl/lane_word_buffer.sv
// lane_word_buffer: byte staging register feeding a PPI output register.
// A staged word moves out once it holds n_i bytes or carries the last byte.
module lane_word_buffer
  import dsi_pkg::*;
#(
  parameter int MAX_LANES = 4,
  parameter int BYTE_W    = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  lane_cnt_t                   n_i,
  input  logic                        push_i,
  input  logic [BYTE_W-1:0]           push_data_i,
  input  logic                        push_last_i,
  input  logic                        out_ready_i,
  output logic                        stall_o,
  output logic [MAX_LANES*BYTE_W-1:0] out_data_o,
  output logic [MAX_LANES-1:0]        out_en_o,
  output logic                        out_valid_o,
  output logic                        out_last_o
);

  localparam int DW = MAX_LANES * BYTE_W;

  logic [DW-1:0]        stg_data_q, stg_data_d;
  lane_cnt_t            stg_cnt_q, stg_cnt_d;
  logic                 stg_last_q, stg_last_d;
  logic [MAX_LANES-1:0] stg_en;

  logic [DW-1:0]        out_data_q;
  logic [MAX_LANES-1:0] out_en_q;
  logic                 out_valid_q;
  logic                 out_last_q;

  logic stg_full;
  logic move;

  assign stg_full = stg_last_q || (stg_cnt_q == n_i);
  assign move     = stg_full && (!out_valid_q || out_ready_i);
  assign stall_o  = stg_full && !move;

  always_comb begin
    for (int l = 0; l < MAX_LANES; l++) begin
      stg_en[l] = (lane_cnt_t'(l) < stg_cnt_q);
    end
  end

  // A byte pushed in the same cycle as a move lands in lane 0 of a
  // freshly cleared word, so unused lanes always read as zero.
  always_comb begin
    stg_data_d = stg_data_q;
    stg_cnt_d  = stg_cnt_q;
    stg_last_d = stg_last_q;
    if (move) begin
      stg_data_d = '0;
      stg_cnt_d  = '0;
      stg_last_d = 1'b0;
    end
    if (push_i) begin
      for (int l = 0; l < MAX_LANES; l++) begin
        if (stg_cnt_d == lane_cnt_t'(l)) begin
          stg_data_d[l*BYTE_W +: BYTE_W] = push_data_i;
        end
      end
      stg_cnt_d  = stg_cnt_d + 3'd1;
      stg_last_d = push_last_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stg_data_q  <= '0;
      stg_cnt_q   <= '0;
      stg_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_en_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      stg_data_q <= stg_data_d;
      stg_cnt_q  <= stg_cnt_d;
      stg_last_q <= stg_last_d;
      if (move) begin
        out_data_q  <= stg_data_q;
        out_en_q    <= stg_en;
        out_valid_q <= 1'b1;
        out_last_q  <= stg_last_q;
      end else if (out_ready_i) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

  assign out_data_o  = out_data_q;
  assign out_en_o    = out_en_q;
  assign out_valid_o = out_valid_q;
  assign out_last_o  = out_last_q;

endmodule

// File: rtl/lane_distributor.sv
// lane_distributor: spreads a packet byte stream across N PPI data lanes.
// Optional LANE_DIST_BYTECNT_EN adds a pkt_bytes length report output.
module lane_distributor
  import dsi_pkg::*;
#(
  parameter int MAX_LANES = 4,
  parameter int BYTE_W    = 8
) (
  input  logic                        dsi_clk,
  input  logic                        dsi_rst,
  input  logic [1:0]                  lane_cfg,
  input  logic [BYTE_W-1:0]           s_data,
  input  logic                        s_valid,
  input  logic                        s_last,
  output logic                        s_ready,
  output logic [MAX_LANES*BYTE_W-1:0] ppi_data,
  output logic [MAX_LANES-1:0]        ppi_lane_en,
  output logic                        ppi_valid,
  input  logic                        ppi_ready,
  output logic                        lane_done
`ifdef LANE_DIST_BYTECNT_EN
  ,
  output logic [15:0]                 pkt_bytes
`endif
);

  dist_state_t state_q;
  lane_cnt_t   n_q;
  logic        run_q;
  logic        done_q;

  logic in_pkt;
  logic stall;
  logic accept;
  logic out_last;

  assign in_pkt  = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
  assign s_ready = run_q && in_pkt && !stall;
  assign accept  = s_valid && s_ready;

  lane_word_buffer #(
    .MAX_LANES (MAX_LANES),
    .BYTE_W    (BYTE_W)
  ) u_buf (
    .clk_i       (dsi_clk),
    .rst_i       (dsi_rst),
    .n_i         (n_q),
    .push_i      (accept),
    .push_data_i (s_data),
    .push_last_i (s_last),
    .out_ready_i (ppi_ready),
    .stall_o     (stall),
    .out_data_o  (ppi_data),
    .out_en_o    (ppi_lane_en),
    .out_valid_o (ppi_valid),
    .out_last_o  (out_last)
  );

  // run_q holds s_ready low until the first edge after reset release.
  always_ff @(posedge dsi_clk or posedge dsi_rst) begin
    if (dsi_rst) begin
      state_q <= ST_IDLE;
      n_q     <= 3'd1;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      run_q  <= 1'b1;
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            n_q     <= eff_lanes(lane_cfg, MAX_LANES);
            state_q <= s_last ? ST_DRAIN : ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (accept && s_last) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (ppi_valid && ppi_ready && out_last) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign lane_done = done_q;

`ifdef LANE_DIST_BYTECNT_EN
  logic [15:0] cnt_q;
  logic [15:0] bytes_q;

  always_ff @(posedge dsi_clk or posedge dsi_rst) begin
    if (dsi_rst) begin
      cnt_q   <= '0;
      bytes_q <= '0;
    end else begin
      if (accept) begin
        if (state_q == ST_IDLE) cnt_q <= 16'd1;
        else if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
      end
      if (state_q == ST_DONE) bytes_q <= cnt_q;
    end
  end

  assign pkt_bytes = bytes_q;
`endif

endmodule

// File: doc/lane_distributor.md
LANE_DISTRIBUTOR -- requirements
Module: lane_distributor

Interface
REQ-001 SHALL have parameter MAX_LANES, default 4, maximum number of PPI data lanes (legal 1..4).
REQ-002 SHALL have parameter BYTE_W, default 8, width of one lane byte.
REQ-003 SHALL have port dsi_clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port dsi_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port lane_cfg  input  2  active lanes minus one (0 = 1 lane, 3 = 4 lanes).
REQ-006 SHALL have port s_data  input  BYTE_W  packet byte stream in transmit order.
REQ-007 SHALL have port s_valid  input  1  s_data valid.
REQ-008 SHALL have port s_last  input  1  current byte is the final byte of the packet.
REQ-009 SHALL have port s_ready  output  1  byte accepted when s_valid and s_ready are both high.
REQ-010 SHALL have port ppi_data  output  MAX_LANES*BYTE_W  lane bytes; lane n at bits [n*BYTE_W +: BYTE_W].
REQ-011 SHALL have port ppi_lane_en  output  MAX_LANES  per-lane byte-valid qualifier for the current word.
REQ-012 SHALL have port ppi_valid  output  1  ppi_data/ppi_lane_en hold a word.
REQ-013 SHALL have port ppi_ready  input  1  PHY takes the word when ppi_valid and ppi_ready are both high.
REQ-014 SHALL have port lane_done  output  1  single-cycle pulse at end of packet.

Function
REQ-015 SHALL distribute packet byte k to lane (k mod N), word (k div N), where N = min(lane_cfg+1, MAX_LANES).
REQ-016 SHALL latch N on the first accepted byte of a packet; lane_cfg changes mid-packet SHALL be ignored until the next packet.
REQ-017 SHALL implement FSM IDLE -> ACTIVE (first byte accepted) -> DRAIN (s_last accepted) -> DONE (final word handshaken) -> IDLE (next cycle).
REQ-018 SHALL use a staging register plus an output register; staging moves to output when staging holds N bytes (or s_last) and (!ppi_valid or ppi_ready).
REQ-019 SHALL deassert s_ready only while a complete staging word is waiting for the output register, and throughout DRAIN and DONE.
REQ-020 SHALL sustain one accepted byte per cycle with ppi_ready held high; latency from the N-th byte accepted to ppi_valid high SHALL be 1 cycle.
REQ-021 SHALL hold ppi_data, ppi_lane_en and ppi_valid stable while ppi_valid=1 and ppi_ready=0.
REQ-022 SHALL set ppi_lane_en to the low N bits for full words; for the final short word, only lanes 0..(L mod N)-1 SHALL be set, where L = packet length in bytes (all N lanes if L mod N = 0).
REQ-023 SHALL drive unused lane bytes (disabled lanes, short final word) to zero.
REQ-024 SHALL pulse lane_done in DONE, i.e. the cycle after the final word's handshake.
REQ-025 SHALL handle a 1-byte packet (s_last on first byte): one word, ppi_lane_en = 0001.
REQ-026 SHALL treat lane_cfg+1 > MAX_LANES as MAX_LANES.

Reset
REQ-027 SHALL, on dsi_rst, asynchronously clear the FSM to IDLE, empty staging and output registers, and zero s_ready, ppi_data, ppi_lane_en, ppi_valid and lane_done; s_ready SHALL rise the first cycle after release.
REQ-028 SHALL discard a packet in progress when reset asserts mid-packet; lane_done SHALL NOT pulse for it.

Configuration
REQ-029 SHALL, with LANE_DIST_BYTECNT_EN defined, add output pkt_bytes (16 bits): cleared on reset, holding the byte count of the last completed packet, updated in DONE and saturating at 16'hFFFF.
REQ-030 SHALL, without LANE_DIST_BYTECNT_EN, have no pkt_bytes port and no counter logic.

Structure
REQ-031 SHALL place the FSM state enum, the lane-count typedef and the LANE_MAX_SUPPORTED=4 constant in shared package dsi_pkg.
REQ-032 SHALL isolate the staging/output register pair in sub-module lane_word_buffer; the FSM and lane_cfg latch SHALL stay in lane_distributor.

Verification
REQ-033 SHALL cover: lane_cfg=3, 8 bytes 01..08, ppi_ready=1 -> words 04030201 and 08070605, ppi_lane_en=1111 on both, lane_done once.
REQ-034 SHALL cover: lane_cfg=1, 5 bytes AA,BB,CC,DD,EE -> words BBAA, DDCC, 00EE; final ppi_lane_en=0001.
REQ-035 SHALL cover: lane_cfg=0, 3 bytes, ppi_ready low 4 cycles on word 2 -> word 2 held stable, s_ready low while the stage is full, no byte lost.
REQ-036 SHALL cover: lane_cfg switched 3->0 after byte 2 of a 6-byte packet -> packet finishes 4-lane (ppi_lane_en 1111 then 0011); next packet is 1-lane.
REQ-037 SHALL cover: dsi_rst asserted after byte 3 of 8 -> all outputs 0 immediately, no lane_done; next packet starts at lane 0.
REQ-038 SHALL cover: with LANE_DIST_BYTECNT_EN, a 1-byte then a 300-byte packet -> pkt_bytes reads 1, then 300.
